pzcorebus_request_fifo: RTL

PZCOREBUS_REQUEST_FIFO -- requirements
Module: pzcorebus_request_fifo

---
 rtl/pzcorebus_request_fifo.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pzcorebus_request_fifo.sv
// +------------------------------------------------------------------------+
// | pzcorebus_request_fifo: independent command / write-data request FIFOs |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module pzcorebus_request_fifo_core #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int THRESHOLD = DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_accept,
  output logic             push_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             almost_full,
  output logic             full,
  output logic             push_fire,
  output logic             pop_fire
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_empty;
  logic             r_full;
  logic             r_almost_full;

  assign push_ready  = !r_full;
  assign pop_valid   = !r_empty;
  assign empty       = r_empty;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign push_fire   = push_valid && !r_full;
  assign pop_fire    = !r_empty && pop_accept;
  assign pop_data    = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    if (push_fire && !pop_fire) begin
      w_count_next = r_count + CW'(1);
    end else if (pop_fire && !push_fire) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Flags are registered from the next count so accept never depends on pop_accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
    end else if (clear) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= (THRESHOLD <= 0);
    end else begin
      if (push_fire) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (pop_fire) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      r_count       <= w_count_next;
      r_empty       <= (w_count_next == '0);
      r_full        <= (w_count_next == CW'(DEPTH));
      r_almost_full <= (32'(w_count_next) >= THRESHOLD);
    end
  end

endmodule

module pzcorebus_request_fifo #(
  parameter int COMMAND_WIDTH     = 64,
  parameter int DATA_WIDTH        = 64,
  parameter int COMMAND_DEPTH     = 2,
  parameter int DATA_DEPTH        = 2,
  parameter int COMMAND_THRESHOLD = COMMAND_DEPTH,
  parameter int DATA_THRESHOLD    = DATA_DEPTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clear,
  input  logic                             i_mcmd_valid,
  output logic                             o_scmd_accept,
  input  logic [COMMAND_WIDTH-1:0]         i_mcmd,
  input  logic                             i_mdata_valid,
  output logic                             o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]            i_mdata,
  input  logic                             i_mdata_last,
  output logic                             o_mcmd_valid,
  input  logic                             i_scmd_accept,
  output logic [COMMAND_WIDTH-1:0]         o_mcmd,
  output logic                             o_mdata_valid,
  input  logic                             i_sdata_accept,
  output logic [DATA_WIDTH-1:0]            o_mdata,
  output logic                             o_mdata_last,
  output logic                             o_cmd_empty,
  output logic                             o_cmd_almost_full,
  output logic                             o_cmd_full,
  output logic                             o_data_empty,
  output logic                             o_data_almost_full,
  output logic                             o_data_full,
  output logic [$clog2(DATA_DEPTH+1)-1:0]  o_burst_count
);

  localparam int BW = $clog2(DATA_DEPTH + 1);

  logic                  w_cmd_push;
  logic                  w_cmd_pop;
  logic                  w_data_push;
  logic                  w_data_pop;
  logic [DATA_WIDTH:0]   w_data_head;
  logic                  w_push_last;
  logic                  w_pop_last;
  logic [BW-1:0]         r_burst_count;

  pzcorebus_request_fifo_core #(
    .WIDTH     (COMMAND_WIDTH),
    .DEPTH     (COMMAND_DEPTH),
    .THRESHOLD (COMMAND_THRESHOLD)
  ) u_cmd_fifo (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .clear       (i_clear),
    .push_valid  (i_mcmd_valid),
    .push_data   (i_mcmd),
    .pop_accept  (i_scmd_accept),
    .push_ready  (o_scmd_accept),
    .pop_valid   (o_mcmd_valid),
    .pop_data    (o_mcmd),
    .empty       (o_cmd_empty),
    .almost_full (o_cmd_almost_full),
    .full        (o_cmd_full),
    .push_fire   (w_cmd_push),
    .pop_fire    (w_cmd_pop)
  );

  pzcorebus_request_fifo_core #(
    .WIDTH     (DATA_WIDTH + 1),
    .DEPTH     (DATA_DEPTH),
    .THRESHOLD (DATA_THRESHOLD)
  ) u_data_fifo (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .clear       (i_clear),
    .push_valid  (i_mdata_valid),
    .push_data   ({i_mdata_last, i_mdata}),
    .pop_accept  (i_sdata_accept),
    .push_ready  (o_sdata_accept),
    .pop_valid   (o_mdata_valid),
    .pop_data    (w_data_head),
    .empty       (o_data_empty),
    .almost_full (o_data_almost_full),
    .full        (o_data_full),
    .push_fire   (w_data_push),
    .pop_fire    (w_data_pop)
  );

  assign o_mdata       = w_data_head[DATA_WIDTH-1:0];
  assign o_mdata_last  = w_data_head[DATA_WIDTH];
  assign w_push_last   = w_data_push && i_mdata_last;
  assign w_pop_last    = w_data_pop && o_mdata_last;
  assign o_burst_count = r_burst_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_burst_count <= '0;
    end else if (i_clear) begin
      r_burst_count <= '0;
    end else if (w_push_last && !w_pop_last) begin
      r_burst_count <= r_burst_count + BW'(1);
    end else if (w_pop_last && !w_push_last) begin
      r_burst_count <= r_burst_count - BW'(1);
    end
  end

endmodule

`default_nettype wire
